// File: rtl/fp_add_issuer.sv
// Initiator-side issuer for the FP adder: buffers operand pairs, issues one at a time,
// masks stale ResultValid for SETTLE cycles, and converts a hung operation into a flagged NaN.
module fp_add_issuer #(
    parameter int DEPTH   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [31:0]                InOp1,
    input  logic [31:0]                InOp2,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [31:0]                OutResult,
    output logic                       OutTimeout,
    output logic [31:0]                AddOp1,
    output logic [31:0]                AddOp2,
    output logic                       AddInputValid,
    input  logic [31:0]                AddResult,
    input  logic                       AddResultValid,
    output logic                       Busy,
    output logic [$clog2(DEPTH+1)-1:0] Count
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int TMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_HOLD} state_e;

    state_e        state_q, state_d;
    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   op1_q, op1_d, op2_q, op2_d, result_q, result_d;
    logic          out_valid_q, out_valid_d, timeout_q, timeout_d, issue_q;
    logic          push, pop;

    // Full is judged on the registered count alone, so a same-cycle pop never frees a slot.
    assign InReady = count_q < CW'(DEPTH);
    assign push    = InValid & InReady;
    assign count_d = count_q + CW'(push) - CW'(pop);

    // NOTE: the operand storage has no reset; Count gates every read, so stale entries are never seen.
    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_ptr_q] <= {InOp1, InOp2};
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no branch can leave one unassigned (no latch).
        state_d     = state_q;
        timer_d     = timer_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        result_d    = result_q;
        timeout_d   = timeout_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    {op1_d, op2_d} = mem_q[rd_ptr_q];
                    pop            = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = (SETTLE == 0) ? S_WAIT : S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_q == TW'(SETTLE - 1)) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (AddResultValid) begin
                    result_d    = AddResult;
                    timeout_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th WAIT cycle without a result.
                    result_d    = QNAN;
                    timeout_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (OutReady) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            out_valid_q <= 1'b0;
            issue_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            out_valid_q <= out_valid_d;
            issue_q     <= (state_d == S_ISSUE);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign AddOp1        = op1_q;
    assign AddOp2        = op2_q;
    assign AddInputValid = issue_q;
    assign OutValid      = out_valid_q;
    assign OutResult     = result_q;
    assign OutTimeout    = timeout_q;
    assign Busy          = (state_q != S_IDLE);
    assign Count         = count_q;

endmodule
